// File: rtl/uncache_wbuf_pkg.sv
// Shared types and entry layout for the uncached store buffer.
package uncache_wbuf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_BUSY = 2'd1,
    LD_BUSY = 2'd2,
    LD_RESP = 2'd3
  } uc_state_e;

  // One buffered store: {wen, addr, wdata}.
  localparam int UC_ENTRY_W   = 68;
  localparam int UC_WDATA_LSB = 0;
  localparam int UC_ADDR_LSB  = 32;
  localparam int UC_WEN_LSB   = 64;

  function automatic logic [UC_ENTRY_W-1:0] uc_pack(input logic [3:0]  wen,
                                                     input logic [31:0] addr,
                                                     input logic [31:0] wdata);
    return {wen, addr, wdata};
  endfunction

endpackage

// File: rtl/uncache_wbuf_if.sv
// Uncache bus handshake between the store buffer (master) and the AXI
// bus controller (slave).
interface uncache_wbuf_if;
  logic        data_uncache_en;
  logic        data_uncache_accept;
  logic [3:0]  data_uncache_wen;
  logic [31:0] data_uncache_addr;
  logic [31:0] data_uncache_wdata;
  logic [31:0] data_uncache_rdata;
  logic        data_uncache_fin;

  modport master (
    output data_uncache_en, data_uncache_wen, data_uncache_addr, data_uncache_wdata,
    input  data_uncache_accept, data_uncache_rdata, data_uncache_fin
  );

  modport slave (
    input  data_uncache_en, data_uncache_wen, data_uncache_addr, data_uncache_wdata,
    output data_uncache_accept, data_uncache_rdata, data_uncache_fin
  );
endinterface

// File: rtl/uc_fifo.sv
// Small synchronous FIFO; pointers wrap naturally (DEPTH is a power of two).
module uc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 68
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Entry storage written at the tail.
  // NOTE: the data array has no reset; count/pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; push and pop on one edge leave count unchanged.
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/uncache_wbuf.sv
// Uncached-access front end: posted store FIFO plus in-order load issue
// over a single-outstanding uncache handshake.
module uncache_wbuf
  import uncache_wbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cpu_req,
  input  logic [3:0]         cpu_wen,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic               cpu_ready,
  output logic [31:0]        cpu_rdata,
  output logic               wbuf_empty,
  uncache_wbuf_if.master     bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  uc_state_e             state, state_nxt;
  logic [31:0]           ld_addr;
  logic                  ld_latch;
  logic [CW-1:0]         count;
  logic                  full, empty;
  logic [UC_ENTRY_W-1:0] head;
  logic                  st_req, ld_req, push, pop, fin;
  logic                  unused_accept;

  assign fin           = bus.data_uncache_fin;
  assign unused_accept = bus.data_uncache_accept;
  assign st_req        = cpu_req & (|cpu_wen);
  assign ld_req        = cpu_req & ~(|cpu_wen);
  assign push          = st_req & ~full;
  assign pop           = (state == ST_BUSY) & fin;
  assign cpu_ready     = push | (state == LD_RESP);
  assign wbuf_empty    = empty & (state != ST_BUSY);

  uc_fifo #(.DEPTH(DEPTH), .WIDTH(UC_ENTRY_W)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (uc_pack(cpu_wen, cpu_addr, cpu_wdata)),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Next-state: stores (buffered or arriving now) always win over a pending load.
  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    ld_latch  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty || push) begin
          state_nxt = ST_BUSY;
        end else if (ld_req) begin
          state_nxt = LD_BUSY;
          ld_latch  = 1'b1;
        end
      end
      // Stay busy while an entry remains after this pop, keeping back-to-back drains gapless.
      ST_BUSY: if (fin) state_nxt = (count > CW'(1) || push) ? ST_BUSY : IDLE;
      LD_BUSY: if (fin) state_nxt = LD_RESP;
      LD_RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request mux: head entry when draining, latched load address when loading.
  always_comb begin
    bus.data_uncache_en    = ((state == ST_BUSY) || (state == LD_BUSY)) & ~fin;
    bus.data_uncache_wen   = '0;
    bus.data_uncache_addr  = '0;
    bus.data_uncache_wdata = '0;
    case (state)
      ST_BUSY: begin
        bus.data_uncache_wen   = head[UC_WEN_LSB +: 4];
        bus.data_uncache_addr  = head[UC_ADDR_LSB +: 32];
        bus.data_uncache_wdata = head[UC_WDATA_LSB +: 32];
      end
      LD_BUSY: bus.data_uncache_addr = ld_addr;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Load address capture on issue and read-data capture on completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_addr   <= '0;
      cpu_rdata <= '0;
    end else begin
      if (ld_latch)                     ld_addr   <= cpu_addr;
      if ((state == LD_BUSY) && fin)    cpu_rdata <= bus.data_uncache_rdata;
    end
  end
endmodule
